// File: rtl/imm_gen_stage_pkg.sv
// Shared RISC-V decode definitions: opcode values, immediate format codes and
// the default datapath width used by the immediate generation stage.
package rv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_e;

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational immediate decoder: picks the instruction format from the
// opcode and assembles the sign- or zero-extended immediate at XLEN bits.
module imm_decode
  import rv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int EN_ZICSR = 1
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output imm_fmt_e        o_fmt,
  output logic            o_illegal
);

  logic [6:0] opcode;

  assign opcode    = i_instr[6:0];
  assign o_illegal = (i_instr[1:0] != 2'b11);

  // Format select and immediate assembly; a non-32-bit encoding always
  // yields an empty immediate regardless of the opcode bits.
  always_comb begin
    o_fmt = FMT_NONE;
    o_imm = '0;
    if (!o_illegal) begin
      case (opcode)
        OP_LOAD, OP_IMM, OP_JALR: begin
          o_fmt = FMT_I;
          o_imm = XLEN'($signed(i_instr[31:20]));
        end
        OP_STORE: begin
          o_fmt = FMT_S;
          o_imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
        end
        OP_BRANCH: begin
          o_fmt = FMT_B;
          o_imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                 i_instr[11:8], 1'b0}));
        end
        OP_LUI, OP_AUIPC: begin
          o_fmt = FMT_U;
          o_imm = XLEN'($signed({i_instr[31:12], 12'b0}));
        end
        OP_JAL: begin
          o_fmt = FMT_J;
          o_imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                 i_instr[30:21], 1'b0}));
        end
        OP_SYSTEM: begin
          // CSR immediate forms (funct3[2] set) carry a 5-bit zimm in rs1.
          if ((EN_ZICSR != 0) && i_instr[14]) begin
            o_fmt = FMT_Z;
            o_imm = XLEN'(i_instr[19:15]);
          end else begin
            o_fmt = FMT_I;
            o_imm = XLEN'($signed(i_instr[31:20]));
          end
        end
        default: begin
          o_fmt = FMT_NONE;
          o_imm = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate generation pipeline stage: decodes on the input side, then holds
// results in an output register backed by a single skid entry so that the
// upstream ready is a pure register output.
//
// Handshake: a beat moves upstream when i_valid && o_ready and downstream when
// o_valid && i_ready. While o_valid is high the output fields stay unchanged
// until the downstream transfer; o_ready is low only while the skid entry is
// occupied, so it never depends on i_ready in the same cycle.
module imm_gen_stage
  import rv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int EN_ZICSR = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  input  logic [31:0]     i_instr,
  output logic            o_ready,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_fmt,
  output logic            o_illegal
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic            illegal;
  } entry_t;

  entry_t dec_entry;
  entry_t out_entry;
  entry_t skid_entry;
  logic   out_valid;
  logic   skid_valid;

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;

  logic up_xfer;
  logic load_out;

  imm_decode #(
    .XLEN     (XLEN),
    .EN_ZICSR (EN_ZICSR)
  ) u_decode (
    .i_instr   (i_instr),
    .o_imm     (dec_imm),
    .o_fmt     (dec_fmt),
    .o_illegal (dec_illegal)
  );

  // Package the incoming beat with its decoded fields.
  always_comb begin
    dec_entry         = '0;
    dec_entry.instr   = i_instr;
    dec_entry.imm     = dec_imm;
    dec_entry.fmt     = dec_fmt;
    dec_entry.illegal = dec_illegal;
  end

  assign o_ready  = !skid_valid;
  assign up_xfer  = i_valid && !skid_valid;
  // The output register may take a new value when it is empty or draining.
  assign load_out = !out_valid || i_ready;

  // Occupancy flags; reset beats flush, flush beats any transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (i_flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_out) begin
      out_valid  <= skid_valid || up_xfer;
      skid_valid <= 1'b0;
    end else if (up_xfer) begin
      skid_valid <= 1'b1;
    end
  end

  // Entry payloads: the skid entry is always older than the input beat, so it
  // refills the output register first to preserve arrival order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_entry  <= '0;
      skid_entry <= '0;
    end else if (!i_flush) begin
      if (load_out) begin
        if (skid_valid) begin
          out_entry <= skid_entry;
        end else if (up_xfer) begin
          out_entry <= dec_entry;
        end
      end else if (up_xfer) begin
        skid_entry <= dec_entry;
      end
    end
  end

  assign o_valid   = out_valid;
  assign o_instr   = out_entry.instr;
  assign o_imm     = out_entry.imm;
  assign o_fmt     = out_entry.fmt;
  assign o_illegal = out_entry.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: a main XLEN=32 instance checked through a
// scoreboard, plus EN_ZICSR=0 and XLEN=64 instances sharing its inputs.
module tb_imm_gen_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        m_ready, m_valid, m_ill;
  logic [31:0] m_instr, m_imm;
  logic [2:0]  m_fmt;

  logic        z_ready, z_valid, z_ill;
  logic [31:0] z_instr, z_imm;
  logic [2:0]  z_fmt;

  logic        w_ready, w_valid, w_ill;
  logic [31:0] w_instr;
  logic [63:0] w_imm;
  logic [2:0]  w_fmt;

  int tests_run    = 0;
  int tests_failed = 0;
  int n_out        = 0;
  logic [67:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .EN_ZICSR(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid),
    .i_instr(in_instr), .o_ready(m_ready), .o_valid(m_valid),
    .i_ready(out_ready), .o_instr(m_instr), .o_imm(m_imm), .o_fmt(m_fmt),
    .o_illegal(m_ill)
  );

  imm_gen_stage #(.XLEN(32), .EN_ZICSR(0)) u_noz (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid),
    .i_instr(in_instr), .o_ready(z_ready), .o_valid(z_valid),
    .i_ready(out_ready), .o_instr(z_instr), .o_imm(z_imm), .o_fmt(z_fmt),
    .o_illegal(z_ill)
  );

  imm_gen_stage #(.XLEN(64), .EN_ZICSR(1)) u_x64 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid),
    .i_instr(in_instr), .o_ready(w_ready), .o_valid(w_valid),
    .i_ready(out_ready), .o_instr(w_instr), .o_imm(w_imm), .o_fmt(w_fmt),
    .o_illegal(w_ill)
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_decode(input logic [31:0] ins,
                                             input bit zicsr,
                                             output logic [2:0] fmt);
    longint v;
    logic [63:0] r;
    v = longint'($signed(ins));
    r = 64'd0;
    fmt = 3'd0;
    if (ins[1:0] == 2'b11) begin
      case (ins[6:0])
        7'h03, 7'h13, 7'h67: begin fmt = 3'd1; r = v >>> 20; end
        7'h23: begin
          fmt = 3'd2;
          r = ((v >>> 25) << 5) | 64'(ins[11:7]);
        end
        7'h63: begin
          fmt = 3'd3;
          r = ((v >>> 31) << 12) | (64'(ins[7]) << 11) |
              (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
        end
        7'h37, 7'h17: begin fmt = 3'd4; r = v & ~64'hFFF; end
        7'h6F: begin
          fmt = 3'd5;
          r = ((v >>> 31) << 20) | (64'(ins[19:12]) << 12) |
              (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
        end
        7'h73: begin
          if (zicsr && ins[14]) begin fmt = 3'd6; r = 64'(ins[19:15]); end
          else begin fmt = 3'd1; r = v >>> 20; end
        end
        default: begin fmt = 3'd0; r = 64'd0; end
      endcase
    end
    return r;
  endfunction

  // ---------------- driver / scoreboard cycle ----------------
  // Inputs are stable at the falling edge; whatever handshakes are visible
  // there happen at the following rising edge.
  task automatic tick();
    logic [2:0]  f;
    logic [63:0] r;
    logic [67:0] got, exp_w;
    @(negedge clk);
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (m_valid && out_ready) begin
        got = {m_instr, m_imm, m_fmt, m_ill};
        tests_run++;
        n_out++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected got=%h (queue empty)", got);
        end else begin
          exp_w = exp_q.pop_front();
          if (got !== exp_w) begin
            tests_failed++;
            $display("FAIL sb_beat got=%h exp=%h", got, exp_w);
          end
        end
      end
      if (in_valid && m_ready) begin
        r = ref_decode(in_instr, 1'b1, f);
        exp_q.push_back({in_instr, r[31:0], f, (in_instr[1:0] != 2'b11)});
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093;
    out_ready = 1'b0;
    tick(); tick();
    tests_run += 6;
    if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid got=%b exp=0", m_valid); end
    if (m_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready got=%b exp=1", m_ready); end
    if (m_instr !== 32'd0) begin tests_failed++; $display("FAIL rst_instr got=%h exp=0", m_instr); end
    if (m_imm !== 32'd0) begin tests_failed++; $display("FAIL rst_imm got=%h exp=0", m_imm); end
    if (m_fmt !== 3'd0) begin tests_failed++; $display("FAIL rst_fmt got=%0d exp=0", m_fmt); end
    if (m_ill !== 1'b0) begin tests_failed++; $display("FAIL rst_ill got=%b exp=0", m_ill); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_vectors();
    logic [31:0] vin [7];
    logic [31:0] vimm [7];
    logic [2:0]  vfmt [7];
    vin  = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000EE3, 32'h12345037,
             32'h300FD073, 32'h00000000, 32'h7FF00093};
    vimm = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000,
             32'h0000001F, 32'h00000000, 32'h000007FF};
    vfmt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd0, 3'd1};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_instr = vin[i];
      tick();
      in_valid = 1'b0;
      tests_run += 4;
      if (m_valid !== 1'b1) begin tests_failed++; $display("FAIL vec%0d_latency valid got=%b exp=1", i, m_valid); end
      if (m_imm !== vimm[i]) begin tests_failed++; $display("FAIL vec%0d_imm got=%h exp=%h", i, m_imm, vimm[i]); end
      if (m_fmt !== vfmt[i]) begin tests_failed++; $display("FAIL vec%0d_fmt got=%0d exp=%0d", i, m_fmt, vfmt[i]); end
      if (m_ill !== (i == 5)) begin tests_failed++; $display("FAIL vec%0d_ill got=%b exp=%b", i, m_ill, (i == 5)); end
      tick();
    end
  endtask

  task automatic test_variants();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h300FD073;
    tick();
    in_valid = 1'b0;
    tests_run += 2;
    if (z_fmt !== 3'd1) begin tests_failed++; $display("FAIL noz_fmt got=%0d exp=1", z_fmt); end
    if (z_imm !== 32'h00000300) begin tests_failed++; $display("FAIL noz_imm got=%h exp=00000300", z_imm); end
    tick();
    in_valid = 1'b1; in_instr = 32'hFFF00093;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (w_imm !== 64'hFFFFFFFFFFFFFFFF) begin tests_failed++; $display("FAIL x64_itype got=%h exp=ffffffffffffffff", w_imm); end
    tick();
    in_valid = 1'b1; in_instr = 32'h80000037;
    tick();
    in_valid = 1'b0;
    tests_run += 2;
    if (w_imm !== 64'hFFFFFFFF80000000) begin tests_failed++; $display("FAIL x64_utype got=%h exp=ffffffff80000000", w_imm); end
    if (w_fmt !== 3'd4) begin tests_failed++; $display("FAIL x64_fmt got=%0d exp=4", w_fmt); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] beats [4];
    int idx, gaps, base;
    bit acc;
    beats = '{32'h00500093, 32'hFE20AE23, 32'h0040006F, 32'hABCDE017};
    idx = 0; gaps = 0; base = n_out;
    for (int c = 0; c < 16 && (n_out - base) < 4; c++) begin
      in_valid  = (idx < 4);
      in_instr  = beats[(idx < 4) ? idx : 0];
      out_ready = !(c >= 1 && c <= 3);
      if (c == 2) begin
        tests_run++;
        if (m_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_ready_drop got=%b exp=0", m_ready); end
      end
      if (c >= 4 && !m_valid) gaps++;
      acc = in_valid && m_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tests_run += 2;
    if ((n_out - base) != 4) begin tests_failed++; $display("FAIL stall_count got=%0d exp=4", n_out - base); end
    if (gaps != 0) begin tests_failed++; $display("FAIL stall_gaps got=%0d exp=0", gaps); end
  endtask

  task automatic test_flush();
    int base;
    base = n_out;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; tick();
    in_instr = 32'h00200113; tick();
    tests_run += 2;
    if (m_valid !== 1'b1) begin tests_failed++; $display("FAIL flush_fill_valid got=%b exp=1", m_valid); end
    if (m_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_fill_ready got=%b exp=0", m_ready); end
    flush = 1'b1; in_instr = 32'h00300193;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tests_run += 2;
    if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_valid got=%b exp=0", m_valid); end
    if (m_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_ready got=%b exp=1", m_ready); end
    out_ready = 1'b1;
    tick(); tick(); tick();
    // Same-cycle beat with an empty stage must also be dropped.
    in_valid = 1'b1; flush = 1'b1; in_instr = 32'h00400213;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
    tests_run += 2;
    if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_same_cycle got=%b exp=0", m_valid); end
    if (n_out != base) begin tests_failed++; $display("FAIL flush_leak got=%0d exp=%0d", n_out, base); end
  endtask

  task automatic test_reset_mid();
    int base;
    base = n_out;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h12345037; tick();
    in_instr = 32'hFE000EE3; tick();
    rst = 1'b1; tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tests_run += 4;
    if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_valid got=%b exp=0", m_valid); end
    if (m_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_ready got=%b exp=1", m_ready); end
    if (m_instr !== 32'd0) begin tests_failed++; $display("FAIL rstmid_instr got=%h exp=0", m_instr); end
    if (n_out != base) begin tests_failed++; $display("FAIL rstmid_leak got=%0d exp=%0d", n_out, base); end
    in_valid = 1'b1; in_instr = 32'h0FF00513;
    tick();
    in_valid = 1'b0;
    tests_run += 2;
    if (m_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_latency got=%b exp=1", m_valid); end
    if (m_instr !== 32'h0FF00513) begin tests_failed++; $display("FAIL rstmid_instr2 got=%h exp=0ff00513", m_instr); end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ops [9];
    logic [31:0] w;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73};
    for (int c = 0; c < 300; c++) begin
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 8)];
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = w;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL random_drain left=%0d exp=0", exp_q.size()); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_vectors();
    test_variants();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
